uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Sits between the UART receiver and the system bus side. Per received frame it:
//   - latches the byte and its error status;
//   - applies the drop policy;
//   - buffers the byte in a FIFO with a valid/ready output;
//   - flags overrun and keeps saturating statistics counters.
//  Owns enable/flush sequencing of the receive path.
// PARAMETERS
//  N_BIT     8   data bits per frame (matches receiver)
//  DEPTH     16  FIFO entries, power of two, >=2
//  DROP_BAD  0   1: bytes with parity/frame error are discarded, not queued
//  CNT_W     16  width of statistics counters
// PORTS
//  clk           in   1              system clock
//  rst           in   1              asynchronous, active-high reset
//  rx_done_tick  in   1              receiver: one-cycle pulse, frame complete
//  rx_data       in   N_BIT          receiver: byte, valid with rx_done_tick
//  parity_error  in   1              receiver: may be high several cycles before/at rx_done_tick
//  frame_error   in   1              receiver: valid only with rx_done_tick
//  enable        in   1              1 = accept frames; 0 = ignore frames
//  flush         in   1              one-cycle request: empty FIFO, clear sticky flags
//  m_valid       out  1              FIFO head valid
//  m_data        out  N_BIT          FIFO head byte
//  m_err         out  2              {frame_err, parity_err} of head byte
//  m_ready       in   1              consumer accepts head when m_valid & m_ready
//  fifo_level    out  $clog2(DEPTH)+1  entries held
//  overrun       out  1              sticky: a frame was lost to a full FIFO
//  good_cnt      out  CNT_W          frames accepted without error (saturating)
//  err_cnt       out  CNT_W          frames with parity or frame error (saturating)
//  drop_cnt      out  CNT_W          frames dropped: overrun or DROP_BAD (saturating)
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, m_valid=0, m_data=0, m_err=0, fifo_level=0.
//   overrun=0; all counters=0; internal parity latch (par_seen)=0.
//  par_seen: set on any cycle with parity_error=1.
//   Cleared in the cycle after rx_done_tick is processed, and on flush.
//  Frame error status (cycle of rx_done_tick): perr = par_seen|parity_error, ferr = frame_error.
//  FSM states:
//   IDLE  -> RUN on enable=1.
//   RUN   -> IDLE on enable=0; RUN -> FLUSH on flush=1 (any state).
//   FLUSH -> RUN if enable=1, else IDLE; FLUSH lasts exactly 1 cycle.
//  In IDLE and FLUSH: rx_done_tick is ignored (no push, no counter change).
//   par_seen is still cleared on that tick.
//  RUN, rx_done_tick=1:
//   - perr|ferr: err_cnt+1. If DROP_BAD: drop_cnt+1, no push. Else push if space.
//   - Otherwise: good_cnt+1, push if space.
//   - Push needed but FIFO full, and no pop this cycle: drop_cnt+1, overrun<=1, byte lost.
//  Full with simultaneous pop: the push is accepted and fifo_level is unchanged.
//  Pop on m_valid & m_ready. m_data/m_err are driven from FIFO head (registered read, zero bubble).
//   A push into an empty FIFO gives m_valid=1 in the following cycle (latency 1).
//  flush:
//   - empties FIFO and sets fifo_level=0, m_valid=0 in the next cycle;
//   - clears overrun and par_seen;
//   - counters are NOT cleared (reset only);
//   - a push coinciding with flush is discarded and not counted.
//  Counters saturate at all-ones and never wrap.
//  enable dropping mid-frame: a pending frame whose tick arrives in IDLE is discarded silently.
// STRUCTURE
//  Shared include uart_defs.vh:
//   - state encodings ST_IDLE/ST_RUN/ST_FLUSH;
//   - ERR_PAR=0, ERR_FRM=1 bit indices;
//   - N_BIT default.
//  Sub-module uart_rx_fifo:
//   - synchronous FIFO, width N_BIT+2, DEPTH entries;
//   - wr/rd pointers with extra wrap bit;
//   - full/empty/level outputs; clr input for flush.
//  Top holds the FSM, par_seen latch, policy logic and counters.
// TESTING
//  1) enable=1, three clean frames 0x41,0x42,0x43, m_ready=1
//     -> m_data 0x41,0x42,0x43 in order; m_err=0; good_cnt=3.
//  2) parity_error high 3 cycles before tick with 0x55, DROP_BAD=0
//     -> head m_err=2'b01; err_cnt=1; the next clean frame has m_err=0.
//  3) DROP_BAD=1, tick with frame_error=1
//     -> no push; err_cnt=1; drop_cnt=1; m_valid stays 0.
//  4) DEPTH=16, m_ready=0, 18 frames
//     -> fifo_level=16, drop_cnt=2, overrun=1.
//     Then push+pop in the same cycle while full -> level stays 16, no drop.
//  5) FIFO holding 5 entries, flush pulse
//     -> next cycle fifo_level=0, m_valid=0, overrun=0; counters unchanged.
//  6) enable=0 then tick -> nothing queued or counted.
//     Assert rst mid-stream -> all outputs zero immediately (asynchronously).
//     Force good_cnt to saturation -> it stays at 0xFFFF.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: FSM state
// encodings, error-status bit positions and the default frame width.
package uart_rx_ctrl_pkg;

   localparam int N_BIT_DEF = 8;

   // Bit positions inside the 2-bit error status that travels with each byte
   localparam int ERR_PAR = 0;
   localparam int ERR_FRM = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Packs parity and frame error flags into the status field layout
   function automatic logic [1:0] pack_err(input logic perr, input logic ferr);
      logic [1:0] e;
      e          = 2'b00;
      e[ERR_PAR] = perr;
      e[ERR_FRM] = ferr;
      return e;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO for received bytes plus their error status.
// Pointers carry an extra wrap bit so full and empty are distinguishable
// without a separate counter. The head entry is presented directly from
// the storage registers, so a byte written in one cycle is visible at the
// output the next cycle with no extra bubble.
module uart_rx_ctrl_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Status flags and the handshake qualification; a write into a full FIFO
   // is only allowed when the head leaves in the same cycle
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      level   = wr_ptr - rd_ptr;
      do_rd   = rd_en && !empty;
      do_wr   = wr_en && (!full || do_rd);
      rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
   end

   // Storage array, written at the tail; contents need no reset because the
   // output is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (do_wr && !clr)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Pointer update; a clear request wins over any simultaneous read or write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-path controller between the UART receiver and the bus side.
// Latches each completed frame with its error status, applies the drop
// policy, queues accepted bytes in a FIFO with a valid/ready head, flags
// overrun and maintains saturating statistics. Also sequences enable and
// flush for the receive path.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int N_BIT    = N_BIT_DEF,
   parameter int DEPTH    = 16,
   parameter int DROP_BAD = 0,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_done_tick,
   input  logic [N_BIT-1:0]         rx_data,
   input  logic                     parity_error,
   input  logic                     frame_error,
   input  logic                     enable,
   input  logic                     flush,
   output logic                     m_valid,
   output logic [N_BIT-1:0]         m_data,
   output logic [1:0]               m_err,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overrun,
   output logic [CNT_W-1:0]         good_cnt,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam bit              DROP    = (DROP_BAD != 0);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t             state;
   state_t             state_nxt;
   logic               par_seen;
   logic               perr;
   logic               ferr;
   logic               bad;
   logic               take;
   logic               want_push;
   logic               pop;
   logic               lost;
   logic               fifo_wr;
   logic               inc_good;
   logic               inc_err;
   logic               inc_drop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [N_BIT+1:0]   fifo_rd_data;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; a flush request pre-empts every state and the flush
   // state itself always lasts a single cycle
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_FLUSH;
      end else begin
         case (state)
            ST_IDLE:  state_nxt = enable ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nxt = enable ? ST_RUN : ST_IDLE;
            ST_FLUSH: state_nxt = enable ? ST_RUN : ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Frame policy: decide whether the current tick is counted, queued,
   // dropped by policy or lost to a full FIFO
   always_comb begin
      perr      = par_seen | parity_error;
      ferr      = frame_error;
      bad       = perr | ferr;
      take      = (state == ST_RUN) && rx_done_tick && !flush;
      want_push = take && !(bad && DROP);
      pop       = m_valid && m_ready;
      lost      = want_push && fifo_full && !pop;
      fifo_wr   = want_push && !lost;
      inc_good  = take && !bad;
      inc_err   = take && bad;
      inc_drop  = (take && bad && DROP) || lost;
   end

   // Parity errors may precede the tick, so they are remembered until the
   // frame they belong to has been handled or the path is flushed
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         par_seen <= 1'b0;
      else if (flush || rx_done_tick)
         par_seen <= 1'b0;
      else if (parity_error)
         par_seen <= 1'b1;
   end

   // Sticky overrun flag, only cleared by flush or reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overrun <= 1'b0;
      else if (flush)
         overrun <= 1'b0;
      else if (lost)
         overrun <= 1'b1;
   end

   // Statistics counters; they hold at all-ones and survive flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         good_cnt <= '0;
         err_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (inc_good && (good_cnt != '1))
            good_cnt <= good_cnt + CNT_ONE;
         if (inc_err && (err_cnt != '1))
            err_cnt <= err_cnt + CNT_ONE;
         if (inc_drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_ONE;
      end
   end

   uart_rx_ctrl_fifo #(
      .WIDTH (N_BIT + 2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .wr_en   (fifo_wr),
      .wr_data ({pack_err(perr, ferr), rx_data}),
      .rd_en   (m_ready),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Head of the FIFO split into byte and error status
   always_comb begin
      m_valid = !fifo_empty;
      m_data  = fifo_rd_data[N_BIT-1:0];
      m_err   = fifo_rd_data[N_BIT+1:N_BIT];
   end

endmodule
